note_led_sequencer: RTL
=======================

Name: note_led_sequencer

Overview:
- Registered, parametrised successor to the combinational note-to-LED decoder. It captures a note code on a valid strobe and maps it to a one-hot scale-degree LED plus an octave indicator.
- Each displayed note runs through a timed SHOW -> BLINK -> IDLE sequence, or stays latched when sticky mode is selected.
- Sits between the note source (keypad or sequencer) and the board LED pins.

Parameters:
- NOTES_PER_OCT, 7, scale degrees per octave; must be <= LED_W.
- NUM_OCT, 4, number of octaves; valid notes are 1..NOTES_PER_OCT*NUM_OCT.
- NOTE_W, 5, width of the note code; must hold NOTES_PER_OCT*NUM_OCT.
- LED_W, 8, width of the degree LED bus; bits at and above NOTES_PER_OCT are always 0.
- HOLD_CYCLES, 1000, cycles of steady display in SHOW; >= 1.
- BLINK_CYCLES, 400, total cycles spent in BLINK; >= 1.
- BLINK_HALF, 50, half-period of the blink toggle; >= 1.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, reset: synchronous, active-low.
- note_valid, in, 1, one-cycle strobe qualifying note.
- note, in, NOTE_W, note code; 0 = rest.
- sticky, in, 1, when 1, the display holds with no timeout; sampled every cycle.
- clear, in, 1, synchronous display clear.
- led, out, LED_W, one-hot scale-degree LEDs.
- oct_led, out, NUM_OCT, one-hot octave LEDs.
- busy, out, 1, high whenever state != IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - led=0, oct_led=0, busy=0, state=IDLE, all counters 0.
  - Reset mid-sequence aborts the sequence immediately.
- Decode: for valid note n (1 <= n <= NOTES_PER_OCT*NUM_OCT):
  - deg = (n-1) mod NOTES_PER_OCT
  - oct = (n-1) / NOTES_PER_OCT
  - the bit pattern is 1<<deg on led and 1<<oct on oct_led.
  - Default example: n=8 gives led=8'b0000_0001 and oct_led=4'b0010.
- Invalid notes: note_valid with n=0 (rest) or n out of range behaves exactly as clear.
- Latency: accepted note_valid at edge k puts the decoded pattern on led and oct_led after edge k. All outputs are registered.
- States:
  - IDLE: led=0, oct_led=0.
    - Accepted valid note -> SHOW, timer=0.
  - SHOW: degree/octave pattern shown steady.
    - If sticky=0 and timer==HOLD_CYCLES-1 -> BLINK, timer=0, phase=on.
    - If sticky=1, the timer is frozen and the state remains SHOW.
  - BLINK: led and oct_led show the pattern when phase=on and 0 when phase=off.
    - Phase toggles every BLINK_HALF cycles.
    - At timer==BLINK_CYCLES-1 -> IDLE.
    - If sticky goes high during BLINK -> SHOW, phase=on, timer frozen.
- Priority at a single edge, highest first: rst_n, clear, note_valid, timer expiry.
  - clear -> IDLE, outputs 0.
  - An accepted note_valid in any state restarts SHOW with the new pattern and timer=0. A new note arriving on the expiry cycle wins.
- Counters:
  - The timer is wide enough for max(HOLD_CYCLES, BLINK_CYCLES) and never wraps; it saturates by state exit.
  - The blink counter resets on entry to BLINK.

Decomposition:
- Package note_led_pkg holds:
  - state enum {IDLE, SHOW, BLINK}
  - function clog2-style width helper
  - default constants NOTES_PER_OCT=7 and NUM_OCT=4
- One sub-module, note_degree_decode (combinational):
  - inputs: note
  - outputs: deg_onehot[LED_W], oct_onehot[NUM_OCT], in_range
  - Reused by future display blocks.
- The FSM, timer and blink logic live in note_led_sequencer.

Test Plan:
- Small-parameter build (HOLD_CYCLES=4, BLINK_CYCLES=6, BLINK_HALF=2, defaults otherwise).
- Reset: hold rst_n=0 for 3 cycles with note_valid=1, note=5 -> led=0, oct_led=0, busy=0 throughout.
- Decode sweep: notes 1..28, sticky=1 -> note 1 gives led=0x01, oct=0001; note 7 gives 0x40, 0001; note 15 gives 0x01, 0100; note 28 gives 0x40, 1000. Led bit 7 is never set.
- Timed sequence: note=10, sticky=0 ->
  - led=0x04, oct=0010 for 4 cycles
  - then BLINK pattern on,on,off,off,on,on
  - then IDLE with busy=0, 10 cycles after acceptance.
- Retrigger: note=3, then note=20 two cycles later -> led=0x20, oct=0100; SHOW restarts and the 4-cycle hold is counted from the second strobe.
- Invalid/clear:
  - note=0 strobe during SHOW -> outputs 0 next cycle, IDLE.
  - note=29 -> same as note=0.
  - clear and note_valid(note=4) on the same cycle -> IDLE, outputs 0.
- Sticky mid-BLINK: sticky=1 on the second BLINK cycle -> SHOW, steady pattern held indefinitely; sticky=0 -> BLINK resumes from frozen timer.

Source files
------------

// File: rtl/note_led_pkg.sv
// Shared types and helpers for the note display blocks.
//   state_e   : sequencer state encoding (IDLE / SHOW / BLINK)
//   width_for : bits needed to hold counts 0..n-1 (minimum 1)
//   DEF_*     : default scale geometry
package note_led_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLINK = 2'd2
    } state_e;

    localparam int unsigned DEF_NOTES_PER_OCT = 7;
    localparam int unsigned DEF_NUM_OCT       = 4;

    // Number of bits required to count from 0 to n-1.
    function automatic int unsigned width_for(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/note_degree_decode.sv
// Combinational note-code decoder.
//   note       : note code, 0 = rest, valid range 1..NOTES_PER_OCT*NUM_OCT
//   deg_onehot : one-hot scale degree, bits >= NOTES_PER_OCT always 0
//   oct_onehot : one-hot octave
//   in_range   : note is a playable code; one-hot outputs are 0 otherwise
module note_degree_decode
    import note_led_pkg::*;
#(
    parameter int unsigned NOTES_PER_OCT = DEF_NOTES_PER_OCT,
    parameter int unsigned NUM_OCT       = DEF_NUM_OCT,
    parameter int unsigned NOTE_W        = 5,
    parameter int unsigned LED_W         = 8
) (
    input  logic [NOTE_W-1:0]  note,
    output logic [LED_W-1:0]   deg_onehot,
    output logic [NUM_OCT-1:0] oct_onehot,
    output logic               in_range
);

    logic [NOTE_W-1:0] idx;

    always_comb begin
        deg_onehot = '0;
        oct_onehot = '0;
        idx        = note - NOTE_W'(1);
        in_range   = (note != '0) && (32'(note) <= 32'(NOTES_PER_OCT * NUM_OCT));
        if (in_range) begin
            deg_onehot = LED_W'(1)   << (idx % NOTE_W'(NOTES_PER_OCT));
            oct_onehot = NUM_OCT'(1) << (idx / NOTE_W'(NOTES_PER_OCT));
        end
    end

endmodule

// File: rtl/note_led_sequencer.sv
// Registered note-to-LED sequencer: captures a note on note_valid, shows it
// steady for HOLD_CYCLES, blinks it for BLINK_CYCLES, then blanks. sticky
// holds the display in SHOW; dropping sticky after a hold that interrupted
// BLINK resumes blinking from the frozen timer.
//   clk, rst_n : clock, synchronous active-low reset
//   note_valid : one-cycle strobe qualifying note
//   note       : note code (0 = rest, out-of-range acts as clear)
//   sticky     : hold display indefinitely while high
//   clear      : synchronous display clear
//   led        : one-hot scale-degree LEDs (registered)
//   oct_led    : one-hot octave LEDs (registered)
//   busy       : state != IDLE (registered)
module note_led_sequencer
    import note_led_pkg::*;
#(
    parameter int unsigned NOTES_PER_OCT = DEF_NOTES_PER_OCT,
    parameter int unsigned NUM_OCT       = DEF_NUM_OCT,
    parameter int unsigned NOTE_W        = 5,
    parameter int unsigned LED_W         = 8,
    parameter int unsigned HOLD_CYCLES   = 1000,
    parameter int unsigned BLINK_CYCLES  = 400,
    parameter int unsigned BLINK_HALF    = 50
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               note_valid,
    input  logic [NOTE_W-1:0]  note,
    input  logic               sticky,
    input  logic               clear,
    output logic [LED_W-1:0]   led,
    output logic [NUM_OCT-1:0] oct_led,
    output logic               busy
);

    localparam int unsigned T_MAX = (HOLD_CYCLES > BLINK_CYCLES) ? HOLD_CYCLES : BLINK_CYCLES;
    localparam int unsigned TW    = width_for(T_MAX);
    localparam int unsigned BW    = width_for(BLINK_HALF);

    state_e             state_q,   state_d;
    logic [TW-1:0]      timer_q,   timer_d;
    logic [BW-1:0]      bcnt_q,    bcnt_d;
    logic               phase_q,   phase_d;
    logic               resume_q,  resume_d;   // SHOW was entered from BLINK via sticky
    logic [LED_W-1:0]   pat_led_q, pat_led_d;
    logic [NUM_OCT-1:0] pat_oct_q, pat_oct_d;
    logic [LED_W-1:0]   led_d;
    logic [NUM_OCT-1:0] oct_led_d;
    logic               busy_d;

    logic [LED_W-1:0]   dec_led;
    logic [NUM_OCT-1:0] dec_oct;
    logic               dec_in_range;

    note_degree_decode #(
        .NOTES_PER_OCT (NOTES_PER_OCT),
        .NUM_OCT       (NUM_OCT),
        .NOTE_W        (NOTE_W),
        .LED_W         (LED_W)
    ) u_decode (
        .note       (note),
        .deg_onehot (dec_led),
        .oct_onehot (dec_oct),
        .in_range   (dec_in_range)
    );

    // State, counters, captured pattern and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bcnt_q    <= '0;
            phase_q   <= 1'b0;
            resume_q  <= 1'b0;
            pat_led_q <= '0;
            pat_oct_q <= '0;
            led       <= '0;
            oct_led   <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bcnt_q    <= bcnt_d;
            phase_q   <= phase_d;
            resume_q  <= resume_d;
            pat_led_q <= pat_led_d;
            pat_oct_q <= pat_oct_d;
            led       <= led_d;
            oct_led   <= oct_led_d;
            busy      <= busy_d;
        end
    end

    // Next state: clear/invalid note, then new note, then timed progression.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bcnt_d    = bcnt_q;
        phase_d   = phase_q;
        resume_d  = resume_q;
        pat_led_d = pat_led_q;
        pat_oct_d = pat_oct_q;

        if (clear || (note_valid && !dec_in_range)) begin
            state_d   = IDLE;
            timer_d   = '0;
            bcnt_d    = '0;
            phase_d   = 1'b0;
            resume_d  = 1'b0;
            pat_led_d = '0;
            pat_oct_d = '0;
        end else if (note_valid) begin
            state_d   = SHOW;
            timer_d   = '0;
            bcnt_d    = '0;
            phase_d   = 1'b1;
            resume_d  = 1'b0;
            pat_led_d = dec_led;
            pat_oct_d = dec_oct;
        end else begin
            case (state_q)
                IDLE: ;
                SHOW: begin
                    if (!sticky) begin
                        if (resume_q) begin
                            // Resume blinking where the hold froze the timer.
                            state_d  = BLINK;
                            bcnt_d   = '0;
                            phase_d  = 1'b1;
                            resume_d = 1'b0;
                        end else if (timer_q == TW'(HOLD_CYCLES - 1)) begin
                            state_d = BLINK;
                            timer_d = '0;
                            bcnt_d  = '0;
                            phase_d = 1'b1;
                        end else begin
                            timer_d = timer_q + TW'(1);
                        end
                    end
                end
                BLINK: begin
                    if (sticky) begin
                        state_d  = SHOW;
                        phase_d  = 1'b1;
                        resume_d = 1'b1;
                    end else if (timer_q == TW'(BLINK_CYCLES - 1)) begin
                        state_d   = IDLE;
                        timer_d   = '0;
                        bcnt_d    = '0;
                        phase_d   = 1'b0;
                        pat_led_d = '0;
                        pat_oct_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                        if (bcnt_q == BW'(BLINK_HALF - 1)) begin
                            bcnt_d  = '0;
                            phase_d = ~phase_q;
                        end else begin
                            bcnt_d = bcnt_q + BW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        led_d     = '0;
        oct_led_d = '0;
        busy_d    = (state_d != IDLE);
        if ((state_d == SHOW) || ((state_d == BLINK) && phase_d)) begin
            led_d     = pat_led_d;
            oct_led_d = pat_oct_d;
        end
    end

endmodule
